me_operand_streamer: RTL

//  Upstream feeder for me_iddmm_top. Accepts operands X and Y as two independent

---
 rtl/me_iddmm_pkg.sv | 17 +
 rtl/me_operand_streamer_if.sv | 32 +++
 rtl/me_operand_buf.sv | 59 +++++
 rtl/me_operand_streamer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/me_iddmm_pkg.sv
// Shared definitions for the IDDMM operand path: FSM encoding and counter sizing.
package me_iddmm_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        GAP    = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4
    } me_state_e;

    // Counter width able to hold 0..n+1 without wrapping.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 2);
    endfunction

endpackage

// File: rtl/me_operand_streamer_if.sv
// Bus bundle of the operand streamer: two load streams in, lockstep beats and status out.
// master = streamer side, slave = producer/core side.
interface me_operand_streamer_if #(
    parameter int unsigned K = 128
);
    logic [K-1:0] s_x_data;
    logic         s_x_valid;
    logic         s_x_ready;
    logic [K-1:0] s_y_data;
    logic         s_y_valid;
    logic         s_y_ready;
    logic         me_start;
    logic [K-1:0] me_x;
    logic         me_x_valid;
    logic [K-1:0] me_y;
    logic         me_y_valid;
    logic         me_valid;
    logic         busy;
    logic         job_done;

    modport master (
        input  s_x_data, s_x_valid, s_y_data, s_y_valid, me_valid,
        output s_x_ready, s_y_ready, me_start, me_x, me_x_valid,
               me_y, me_y_valid, busy, job_done
    );

    modport slave (
        output s_x_data, s_x_valid, s_y_data, s_y_valid, me_valid,
        input  s_x_ready, s_y_ready, me_start, me_x, me_x_valid,
               me_y, me_y_valid, busy, job_done
    );
endinterface

// File: rtl/me_operand_buf.sv
// N x K operand bank: sequential write port with fill counter, registered read port, full flag.
module me_operand_buf
    import me_iddmm_pkg::*;
#(
    parameter int unsigned K = 128,
    parameter int unsigned N = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic [K-1:0]                      wr_data,
    input  logic                              rd_en,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] rd_addr,
    input  logic                              clear,
    output logic [K-1:0]                      rd_data,
    output logic                              full,
    output logic                              full_nxt_c,
    output logic                              nonempty_c
);
    localparam int unsigned CW = cnt_w(N);
    localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;

    logic [K-1:0]  mem [N];
    logic [CW-1:0] wr_cnt;
    logic          wr_fire;

    assign wr_fire    = wr_en && !full;
    assign full_nxt_c = full || (wr_fire && (wr_cnt == CW'(N - 1)));
    assign nonempty_c = (wr_cnt != '0);

    // Fill counter and full flag; clear drops the buffered job.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_cnt <= '0;
            full   <= 1'b0;
        end else if (wr_fire) begin
            wr_cnt <= wr_cnt + CW'(1);
            full   <= (wr_cnt == CW'(N - 1));
        end
    end

    // Storage write; word i lands at address i.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[AW'(wr_cnt)] <= wr_data;
        end
    end

    // Registered read; returns zero when not reading so idle/pad beats are clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end
endmodule

// File: rtl/me_operand_streamer.sv
// Operand feeder for me_iddmm_top: buffers X/Y, starts the core, streams N+1 lockstep beats,
// then waits for N result strobes. Optional ping/pong banks with ME_STREAMER_DBLBUF_EN.
module me_operand_streamer
    import me_iddmm_pkg::*;
#(
    parameter int unsigned K         = 128,
    parameter int unsigned N         = 32,
    parameter int unsigned START_GAP = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    me_operand_streamer_if.master  bus
);
    localparam int unsigned CW = cnt_w(N);
    localparam int unsigned GW = cnt_w(START_GAP);
    localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
`ifdef ME_STREAMER_DBLBUF_EN
    localparam int unsigned NB = 2;
`else
    localparam int unsigned NB = 1;
`endif

    me_state_e     state;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] res_cnt;
    logic [GW-1:0] gap_cnt;
    logic          load_sel;
    logic          rd_sel;

    logic [NB-1:0] load_mask, rd_mask;
    logic [NB-1:0] x_wr, y_wr, x_full, y_full, x_full_nxt, y_full_nxt;
    logic [NB-1:0] x_nonempty, y_nonempty, rd_en_v, release_v;
    logic [K-1:0]  x_rd [NB];
    logic [K-1:0]  y_rd [NB];
    logic [K-1:0]  x_beat_c, y_beat_c;

    logic          rd_en_c;
    logic [AW-1:0] rd_addr_c;
    logic          start_c, stream_end_c, drain_end_c;

    assign bus.s_x_ready = ~|(x_full & load_mask);
    assign bus.s_y_ready = ~|(y_full & load_mask);
    assign x_wr          = load_mask & {NB{bus.s_x_valid & bus.s_x_ready}};
    assign y_wr          = load_mask & {NB{bus.s_y_valid & bus.s_y_ready}};
    assign rd_en_v       = rd_mask & {NB{rd_en_c}};

    assign start_c      = (state == IDLE) && (|(x_full_nxt & load_mask)) && (|(y_full_nxt & load_mask));
    assign stream_end_c = (state == STREAM) && (beat_cnt == CW'(N));
    assign drain_end_c  = (state == DRAIN) && bus.me_valid && (res_cnt == CW'(N - 1));

    assign bus.busy = (state != IDLE) || (|x_nonempty) || (|y_nonempty);

    for (genvar b = 0; b < NB; b++) begin : g_bank
        assign load_mask[b] = (load_sel == 1'(b));
        assign rd_mask[b]   = (rd_sel == 1'(b));

        me_operand_buf #(.K(K), .N(N)) u_x_buf (
            .clk        (clk),
            .rst        (rst),
            .wr_en      (x_wr[b]),
            .wr_data    (bus.s_x_data),
            .rd_en      (rd_en_v[b]),
            .rd_addr    (rd_addr_c),
            .clear      (release_v[b]),
            .rd_data    (x_rd[b]),
            .full       (x_full[b]),
            .full_nxt_c (x_full_nxt[b]),
            .nonempty_c (x_nonempty[b])
        );

        me_operand_buf #(.K(K), .N(N)) u_y_buf (
            .clk        (clk),
            .rst        (rst),
            .wr_en      (y_wr[b]),
            .wr_data    (bus.s_y_data),
            .rd_en      (rd_en_v[b]),
            .rd_addr    (rd_addr_c),
            .clear      (release_v[b]),
            .rd_data    (y_rd[b]),
            .full       (y_full[b]),
            .full_nxt_c (y_full_nxt[b]),
            .nonempty_c (y_nonempty[b])
        );
    end

`ifdef ME_STREAMER_DBLBUF_EN
    // Ping/pong: a starting job reads the bank just filled; loading moves to the other bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_sel <= 1'b0;
            rd_sel   <= 1'b0;
        end else if (start_c) begin
            rd_sel   <= load_sel;
            load_sel <= ~load_sel;
        end
    end
    assign release_v = rd_mask & {NB{stream_end_c}};
`else
    assign load_sel  = 1'b0;
    assign rd_sel    = 1'b0;
    assign release_v = {NB{drain_end_c}};
`endif

    // Read issue: word 0 on the last gap cycle, then word j+1 while beat j is on the bus.
    always_comb begin
        rd_en_c   = 1'b0;
        rd_addr_c = '0;
        if ((state == GAP) && (gap_cnt == GW'(START_GAP - 1))) begin
            rd_en_c = 1'b1;
        end else if ((state == STREAM) && (beat_cnt < CW'(N - 1))) begin
            rd_en_c   = 1'b1;
            rd_addr_c = AW'(beat_cnt + CW'(1));
        end
    end

    // Beat data comes straight from the bank read registers; idle banks read zero.
    always_comb begin
        x_beat_c = '0;
        y_beat_c = '0;
        for (int b = 0; b < NB; b++) begin
            x_beat_c |= x_rd[b];
            y_beat_c |= y_rd[b];
        end
    end
    assign bus.me_x = x_beat_c;
    assign bus.me_y = y_beat_c;

    // Job sequencer with registered control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            beat_cnt       <= '0;
            res_cnt        <= '0;
            gap_cnt        <= '0;
            bus.me_start   <= 1'b0;
            bus.me_x_valid <= 1'b0;
            bus.me_y_valid <= 1'b0;
            bus.job_done   <= 1'b0;
        end else begin
            bus.me_start <= 1'b0;
            bus.job_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_c) begin
                        state        <= START;
                        bus.me_start <= 1'b1;
                    end
                end
                START: begin
                    state   <= GAP;
                    gap_cnt <= '0;
                end
                GAP: begin
                    if (gap_cnt == GW'(START_GAP - 1)) begin
                        state          <= STREAM;
                        gap_cnt        <= '0;
                        beat_cnt       <= '0;
                        bus.me_x_valid <= 1'b1;
                        bus.me_y_valid <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                STREAM: begin
                    if (stream_end_c) begin
                        state          <= DRAIN;
                        beat_cnt       <= '0;
                        res_cnt        <= '0;
                        bus.me_x_valid <= 1'b0;
                        bus.me_y_valid <= 1'b0;
                    end else begin
                        beat_cnt <= beat_cnt + CW'(1);
                    end
                end
                DRAIN: begin
                    if (drain_end_c) begin
                        state        <= IDLE;
                        res_cnt      <= '0;
                        bus.job_done <= 1'b1;
                    end else if (bus.me_valid) begin
                        res_cnt <= res_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
